// File: rtl/fpu_issue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fpu_issue_if : instruction-in / FPU / writeback bundle           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fpu_issue_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_int;
  logic        in_ready;
  logic [31:0] fpu_inst;
  logic        fpu_is_legl;
  logic [31:0] fpu_from_intreg;
  logic        fpu_hazard;
  logic [31:0] fpu_to_intreg;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] stall_cnt;

  modport master (
    output in_valid, in_inst, in_int, fpu_hazard, fpu_to_intreg,
    input  in_ready, fpu_inst, fpu_is_legl, fpu_from_intreg,
           wb_valid, wb_rd, wb_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_inst, in_int, fpu_hazard, fpu_to_intreg,
    output in_ready, fpu_inst, fpu_is_legl, fpu_from_intreg,
           wb_valid, wb_rd, wb_data, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fpu_issue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fpu_issue : FP instruction queue, in-order issue under hazard,   |
// | integer-writeback latency pipe. Option: FPU_ISSUE_BYPASS_EN.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fpu_issue #(
  parameter int DEPTH      = 4,
  parameter int RESULT_LAT = 3
) (
  input  wire logic   clk,
  input  wire logic   rst,
  fpu_issue_if.slave  bus
);
  localparam int              c_ADDR_W = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_FULL = (c_ADDR_W + 1)'(DEPTH);

  logic [31:0]              r_inst_mem [DEPTH];
  logic [31:0]              r_int_mem  [DEPTH];
  logic [c_ADDR_W-1:0]      r_wp;
  logic [c_ADDR_W-1:0]      r_rp;
  logic [c_ADDR_W:0]        r_count;
  logic [31:0]              r_from_int;
  logic [15:0]              r_stall;
  logic [RESULT_LAT-1:0]    r_wr_sr;
  logic [RESULT_LAT-1:0][4:0] r_rd_sr;

  logic        w_empty;
  logic        w_full;
  logic        w_byp;
  logic        w_issue;
  logic        w_pop;
  logic        w_push;
  logic        w_int_wr;
  logic [31:0] w_iss_inst;
  logic [31:0] w_iss_int;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);

`ifdef FPU_ISSUE_BYPASS_EN
  // Reset gating keeps fpu_inst/fpu_is_legl at zero while rst is held.
  assign w_byp = ~rst & w_empty & bus.in_valid;
`else
  assign w_byp = 1'b0;
`endif

  assign w_iss_inst = w_empty ? bus.in_inst : r_inst_mem[r_rp];
  assign w_iss_int  = w_empty ? bus.in_int  : r_int_mem[r_rp];

  assign w_issue = (~w_empty | w_byp) & ~bus.fpu_hazard;
  assign w_pop   = w_issue & ~w_empty;
  // A bypassed instruction that issues immediately is never stored.
  assign w_push  = bus.in_valid & ~w_full & ~(w_byp & w_issue);

  assign w_int_wr = (w_iss_inst[6:0] == 7'b1010011) &&
                    ((w_iss_inst[31:27] == 5'b11000) ||
                     (w_iss_inst[31:27] == 5'b11100) ||
                     (w_iss_inst[31:27] == 5'b10100));

  assign bus.in_ready        = ~w_full;
  assign bus.fpu_inst        = (~w_empty | w_byp) ? w_iss_inst : 32'h0;
  assign bus.fpu_is_legl     = w_issue;
  assign bus.fpu_from_intreg = r_from_int;
  assign bus.stall_cnt       = r_stall;
  assign bus.wb_rd           = r_rd_sr[RESULT_LAT-1];
  assign bus.wb_valid        = r_wr_sr[RESULT_LAT-1] & (r_rd_sr[RESULT_LAT-1] != 5'd0);
  assign bus.wb_data         = bus.fpu_to_intreg;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wp] <= bus.in_inst;
      r_int_mem[r_wp]  <= bus.in_int;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_from_int <= 32'h0;
      r_stall    <= 16'h0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_issue) r_from_int <= w_iss_int;
      if (!w_empty && bus.fpu_hazard && r_stall != 16'hFFFF)
        r_stall <= r_stall + 1'b1;
    end
  end

  // Writeback latency pipe: slot 0 is loaded on every edge, tail drives wb_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_sr <= '0;
      r_rd_sr <= '0;
    end else begin
      r_wr_sr[0] <= w_issue & w_int_wr;
      r_rd_sr[0] <= w_issue ? w_iss_inst[11:7] : 5'd0;
      for (int i = 1; i < RESULT_LAT; i++) begin
        r_wr_sr[i] <= r_wr_sr[i-1];
        r_rd_sr[i] <= r_rd_sr[i-1];
      end
    end
  end
endmodule
`default_nettype wire
